// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: architecture address map,
// one-hot target select bit positions and FSM state encoding.
package mem_bus_arbiter_pkg;

  localparam logic [31:0] ARCH_ROM_START   = 32'h0000_0000;
  localparam logic [31:0] ARCH_ROM_SIZE    = 32'h0000_1000;
  localparam logic [31:0] ARCH_RAM_START   = 32'h0000_1000;
  localparam logic [31:0] ARCH_RAM_SIZE    = 32'h0000_1000;
  localparam logic [31:0] ARCH_UART_SEND   = 32'hFFFF_FFF0;
  localparam logic [31:0] ARCH_UART_CONFIG = 32'hFFFF_FFF1;
  localparam logic [31:0] ARCH_OUT_PORT    = 32'hFFFF_FFF2;

  localparam int SEL_W           = 5;
  localparam int SEL_ROM         = 0;
  localparam int SEL_RAM         = 1;
  localparam int SEL_UART_SEND   = 2;
  localparam int SEL_UART_CONFIG = 3;
  localparam int SEL_OUT_PORT    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_addr_decoder.sv
// Combinational address decode: one-hot target select plus the target-relative
// address (base subtracted for ROM/RAM, passed through otherwise).
module mem_addr_decoder
  import mem_bus_arbiter_pkg::*;
#(
  parameter logic [31:0] ROM_START   = ARCH_ROM_START,
  parameter logic [31:0] ROM_SIZE    = ARCH_ROM_SIZE,
  parameter logic [31:0] RAM_START   = ARCH_RAM_START,
  parameter logic [31:0] RAM_SIZE    = ARCH_RAM_SIZE,
  parameter logic [31:0] UART_SEND   = ARCH_UART_SEND,
  parameter logic [31:0] UART_CONFIG = ARCH_UART_CONFIG,
  parameter logic [31:0] OUT_PORT    = ARCH_OUT_PORT
) (
  input  logic [31:0]      addr,
  output logic [SEL_W-1:0] sel,
  output logic [31:0]      t_addr
);

  // Region ends are 33 bits wide so a region touching the top of the map
  // does not wrap to zero and swallow everything.
  localparam logic [32:0] ROM_END = {1'b0, ROM_START} + {1'b0, ROM_SIZE};
  localparam logic [32:0] RAM_END = {1'b0, RAM_START} + {1'b0, RAM_SIZE};

  logic [32:0] addr_x;

  assign addr_x = {1'b0, addr};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else chain can leave it unassigned and infer a latch.
  always_comb begin
    sel    = '0;
    t_addr = addr;
    if (addr >= ROM_START && addr_x < ROM_END) begin
      sel[SEL_ROM] = 1'b1;
      t_addr       = addr - ROM_START;
    end else if (addr >= RAM_START && addr_x < RAM_END) begin
      sel[SEL_RAM] = 1'b1;
      t_addr       = addr - RAM_START;
    end else if (addr == UART_SEND) begin
      sel[SEL_UART_SEND] = 1'b1;
    end else if (addr == UART_CONFIG) begin
      sel[SEL_UART_CONFIG] = 1'b1;
    end else if (addr == OUT_PORT) begin
      sel[SEL_OUT_PORT] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester, round-robin memory bus arbiter with a fixed three-cycle
// IDLE -> ACCESS -> RESP transaction per access.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter logic [31:0] ROM_START   = ARCH_ROM_START,
  parameter logic [31:0] ROM_SIZE    = ARCH_ROM_SIZE,
  parameter logic [31:0] RAM_START   = ARCH_RAM_START,
  parameter logic [31:0] RAM_SIZE    = ARCH_RAM_SIZE,
  parameter logic [31:0] UART_SEND   = ARCH_UART_SEND,
  parameter logic [31:0] UART_CONFIG = ARCH_UART_CONFIG,
  parameter logic [31:0] OUT_PORT    = ARCH_OUT_PORT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [31:0]      m0_addr,
  input  logic [7:0]       m0_wdata,
  output logic [7:0]       m0_rdata,
  output logic             m0_ack,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [31:0]      m1_addr,
  input  logic [7:0]       m1_wdata,
  output logic [7:0]       m1_rdata,
  output logic             m1_ack,
  output logic [31:0]      s_addr,
  output logic [7:0]       s_wdata,
  output logic             s_we,
  output logic [SEL_W-1:0] sel,
  input  logic [7:0]       rom_rdata,
  input  logic [7:0]       ram_rdata,
  output logic             bus_err
);

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  resp_q, resp_d;

  logic [SEL_W-1:0] dec_sel;
  logic [31:0]      dec_addr;
  logic             in_access;
  logic             in_resp;

  mem_addr_decoder #(
    .ROM_START  (ROM_START),
    .ROM_SIZE   (ROM_SIZE),
    .RAM_START  (RAM_START),
    .RAM_SIZE   (RAM_SIZE),
    .UART_SEND  (UART_SEND),
    .UART_CONFIG(UART_CONFIG),
    .OUT_PORT   (OUT_PORT)
  ) u_decoder (
    .addr  (addr_q),
    .sel   (dec_sel),
    .t_addr(dec_addr)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_d       = resp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          state_d = ST_ACCESS;
          // On a tie the requester that was not served last wins.
          grant_d      = (m0_req && m1_req) ? ~last_grant_q : m1_req;
          last_grant_d = grant_d;
          we_d         = grant_d ? m1_we    : m0_we;
          addr_d       = grant_d ? m1_addr  : m0_addr;
          wdata_d      = grant_d ? m1_wdata : m0_wdata;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        resp_d  = 8'h00;
        if (!we_q && dec_sel[SEL_ROM]) resp_d = rom_rdata;
        if (!we_q && dec_sel[SEL_RAM]) resp_d = ram_rdata;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_q       <= resp_d;
    end
  end

  // Outputs are decoded from the state register, so reset clears them at once.
  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);

  assign sel     = in_access ? dec_sel : '0;
  assign s_we    = in_access & we_q & (|dec_sel);
  assign s_addr  = in_access ? dec_addr : '0;
  assign s_wdata = in_access ? wdata_q : '0;

  assign m0_ack   = in_resp & ~grant_q;
  assign m1_ack   = in_resp & grant_q;
  assign m0_rdata = m0_ack ? resp_q : 8'h00;
  assign m1_rdata = m1_ack ? resp_q : 8'h00;
  assign bus_err  = in_resp & ~(|dec_sel);

endmodule
